// File: rtl/coreparam.sv
// Core-wide parameters shared by the host-memory path: data widths, requester
// port IDs and the memory-port arbiter state encoding.
package coreparam;

  localparam int XLEN       = 32;
  localparam int fetchWidth = 32;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: on a tie the port not granted last wins;
// last_grant advances only when the caller reports a completed handshake.
module rr_arbiter2
  import coreparam::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    winner = PORT_IFU;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[PORT_LSU]) begin
      winner = PORT_LSU;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant[winner] = 1'b1;
    end
  end

  // Resetting to LSU makes IFU the winner of the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_LSU;
    end else if (advance) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single host-memory port between instruction fetch and load/store:
// one outstanding transaction, round-robin acceptance, sticky latency flag.
module mem_port_arbiter
  import coreparam::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       ifu_req_address,
  input  logic [1:0]            ifu_req_length,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  output logic [XLEN-1:0]       ifu_resp_address,
  output logic [fetchWidth-1:0] ifu_resp_data,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  input  logic [XLEN-1:0]       lsu_req_address,
  input  logic [1:0]            lsu_req_length,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  output logic [XLEN-1:0]       lsu_resp_address,
  output logic [fetchWidth-1:0] lsu_resp_data,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [XLEN-1:0]       mem_req_address,
  output logic [1:0]            mem_req_length,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic [XLEN-1:0]       mem_resp_address,
  input  logic [fetchWidth-1:0] mem_resp_data,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      ifu_grants,
  output logic [CNT_W-1:0]      lsu_grants
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state, state_next;
  logic             owner;
  logic             owner_resp_ready;
  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic             winner;
  logic             accept;
  logic [CNT_W-1:0] timeout_cnt;

  // Arbitration only runs in IDLE, so the grant itself is the accept ready.
  assign arb_req = {lsu_req_valid, ifu_req_valid} & {2{state == ST_IDLE}};
  assign accept  = |arb_req;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (accept),
    .winner  (winner),
    .grant   (grant)
  );

  assign ifu_resp_address = mem_resp_address;
  assign ifu_resp_data    = mem_resp_data;
  assign lsu_resp_address = mem_resp_address;
  assign lsu_resp_data    = mem_resp_data;
  assign owner_resp_ready = (owner == PORT_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output is defaulted before the case so no path infers a latch.
  always_comb begin
    state_next     = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        ifu_req_ready = grant[PORT_IFU];
        lsu_req_ready = grant[PORT_LSU];
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        mem_resp_ready = owner_resp_ready;
        ifu_resp_valid = mem_resp_valid && (owner == PORT_IFU);
        lsu_resp_valid = mem_resp_valid && (owner == PORT_LSU);
        if (mem_resp_valid && owner_resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: the latched address/length are pure datapath and carry no reset;
  // they are only observed while mem_req_valid is high, after a fresh load.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_req_address <= (winner == PORT_LSU) ? lsu_req_address : ifu_req_address;
      mem_req_length  <= (winner == PORT_LSU) ? lsu_req_length  : ifu_req_length;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= PORT_IFU;
      ifu_grants  <= '0;
      lsu_grants  <= '0;
      timeout_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        owner <= winner;
        if (winner == PORT_LSU) lsu_grants <= lsu_grants + CNT_W'(1);
        else                    ifu_grants <= ifu_grants + CNT_W'(1);
      end
      if (state == ST_ISSUE && mem_req_ready) begin
        timeout_cnt <= '0;
      end else if (state == ST_WAIT && !mem_resp_valid && timeout_cnt != '1) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
      // Flag only; the outstanding transaction keeps waiting for its response.
      if (timeout_cnt == TIMEOUT_LIMIT) timeout_err <= 1'b1;
    end
  end

endmodule
